// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared state, grant encodings and default widths for the memory port arbiter
package mem_arb_pkg;
  typedef enum logic [1:0] {ARB_IDLE, ARB_IFETCH, ARB_DATA} arb_state_t;
  localparam logic GNT_IF = 1'b0;
  localparam logic GNT_DM = 1'b1;
  localparam int ADDR_W_DEF = 32;
  localparam int DATA_W_DEF = 32;
endpackage

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: round-robin sharing of one single-ported memory between fetch and data stages
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_ready,
  input  logic              dm_rd,
  input  logic              dm_wr,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  output logic [DATA_W-1:0] dm_rdata,
  output logic              dm_ready,
  output logic              stall_if,
  output logic              stall_mem,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack
);
  arb_state_t state;
  logic last_gnt, dm_pend, gnt_dm;
  assign dm_pend = dm_rd | dm_wr;
  // data wins when it is the only requester or when fetch was served last
  assign gnt_dm = dm_pend & (~if_req | last_gnt == GNT_IF);
  assign if_ready = ~rst & mem_ack & state == ARB_IFETCH;
  assign dm_ready = ~rst & mem_ack & state == ARB_DATA;
  assign stall_if = if_req & ~if_ready;
  assign stall_mem = dm_pend & ~dm_ready;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ARB_IDLE;
      last_gnt <= GNT_IF;
      mem_req <= 1'b0;
      mem_we <= 1'b0;
      mem_addr <= '0;
      mem_wdata <= '0;
      if_rdata <= '0;
      dm_rdata <= '0;
    end else begin
      case (state)
        ARB_IDLE: if (if_req | dm_pend) begin
          state <= gnt_dm ? ARB_DATA : ARB_IFETCH;
          last_gnt <= gnt_dm ? GNT_DM : GNT_IF;
          mem_req <= 1'b1;
          mem_we <= gnt_dm & dm_wr;
          mem_addr <= gnt_dm ? dm_addr : if_addr;
          mem_wdata <= gnt_dm ? dm_wdata : mem_wdata;
        end
        ARB_IFETCH: if (mem_ack) begin
          if_rdata <= mem_rdata;
          mem_req <= 1'b0;
          state <= ARB_IDLE;
        end
        ARB_DATA: if (mem_ack) begin
          dm_rdata <= mem_we ? dm_rdata : mem_rdata;
          mem_req <= 1'b0;
          state <= ARB_IDLE;
        end
        default: state <= ARB_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: scoreboard bench with a latency-programmable memory model
module tb_mem_port_arbiter;
  import mem_arb_pkg::*;
  typedef struct {
    logic        dm;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
  } exp_t;
  logic clk = 0, rst = 1;
  logic if_req = 0, dm_rd = 0, dm_wr = 0, mem_ack, if_ready, dm_ready;
  logic stall_if, stall_mem, mem_req, mem_we;
  logic [31:0] if_addr = 0, dm_addr = 0, dm_wdata = 0, if_rdata, dm_rdata;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  int total = 0, bad = 0, ack_dly = 0, cnt = 0;
  logic force_ack = 0, pend = 0, tb_last = GNT_IF;
  logic [31:0] exp_if = 0, exp_dm = 0;
  exp_t exp_q[$];
  always #5 clk = ~clk;
  mem_port_arbiter dut (
    .clk(clk), .rst(rst), .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata),
    .if_ready(if_ready), .dm_rd(dm_rd), .dm_wr(dm_wr), .dm_addr(dm_addr),
    .dm_wdata(dm_wdata), .dm_rdata(dm_rdata), .dm_ready(dm_ready),
    .stall_if(stall_if), .stall_mem(stall_mem), .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  function automatic logic [31:0] mem_val(input logic [31:0] a);
    return a == 32'h40 ? 32'h2002_0005 : a * 3 + 32'h1000;
  endfunction
  function automatic logic has(input logic dm);
    foreach (exp_q[i]) if (exp_q[i].dm == dm) return 1'b1;
    return 1'b0;
  endfunction
  task automatic push(input logic dm, input logic we, input logic [31:0] a, input logic [31:0] wd);
    exp_t e;
    e.dm = dm; e.we = we; e.addr = a; e.wdata = wd;
    exp_q.push_back(e);
    tb_last = dm;
  endtask
  task automatic wait_done(input string tag);
    int n = 0;
    while (exp_q.size() != 0 && n < 60) begin
      @(posedge clk); #2;
      n++;
      if (!has(1'b0)) if_req = 0;
      if (!has(1'b1)) begin dm_rd = 0; dm_wr = 0; end
    end
    if (exp_q.size() != 0) begin
      chk(tag, exp_q.size(), 0);
      exp_q.delete();
    end
    if_req = 0; dm_rd = 0; dm_wr = 0;
    @(posedge clk); #2;
  endtask
  // memory model: acks ack_dly cycles after mem_req is first seen
  initial begin
    mem_ack = 0; mem_rdata = 0;
    forever begin
      @(posedge clk); #1;
      if (force_ack) begin
        mem_ack = 1; mem_rdata = 32'hBAD0_BAD0; cnt = 0;
      end else if (mem_req) begin
        if (cnt >= ack_dly) begin
          mem_ack = 1; mem_rdata = mem_val(mem_addr); cnt = 0;
        end else begin
          mem_ack = 0; cnt++;
        end
      end else begin
        mem_ack = 0; cnt = 0;
      end
    end
  end
  always @(negedge clk) if (!rst) begin
    exp_t e;
    if (pend) begin
      chk("if_rdata", if_rdata, exp_if);
      chk("dm_rdata", dm_rdata, exp_dm);
      pend = 0;
    end
    if (if_ready || dm_ready) begin
      if (exp_q.size() == 0) chk("spurious_ready", {if_ready, dm_ready}, 0);
      else begin
        e = exp_q.pop_front();
        chk("both_ready", if_ready & dm_ready, 0);
        chk("grant", dm_ready, e.dm);
        chk("mem_addr", mem_addr, e.addr);
        chk("mem_we", mem_we, e.we);
        if (e.we) chk("mem_wdata", mem_wdata, e.wdata);
        chk("stall_if", stall_if, e.dm ? if_req : 1'b0);
        chk("stall_mem", stall_mem, e.dm ? 1'b0 : (dm_rd | dm_wr));
        if (!e.dm) exp_if = mem_val(e.addr);
        else if (!e.we) exp_dm = mem_val(e.addr);
        pend = 1;
      end
    end
  end
  initial begin
    logic [1:0] sel;
    logic w;
    force_ack = 1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_mem_req", mem_req, 0);
    chk("rst_mem_we", mem_we, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_wdata", mem_wdata, 0);
    chk("rst_if_rdata", if_rdata, 0);
    chk("rst_dm_rdata", dm_rdata, 0);
    chk("rst_ready", {if_ready, dm_ready}, 0);
    @(posedge clk); #2;
    force_ack = 0; rst = 0;
    @(posedge clk); #2;
    ack_dly = 2;
    push(GNT_IF, 0, 32'h40, 0);
    if_req = 1; if_addr = 32'h40;
    @(negedge clk);
    chk("stall_if_pending", stall_if, 1);
    @(posedge clk); #2;
    chk("fetch_mem_req", mem_req, 1);
    chk("fetch_mem_addr", mem_addr, 32'h40);
    chk("fetch_stall_held", stall_if, 1);
    wait_done("fetch_timeout");
    ack_dly = 0;
    push(GNT_DM, 0, 32'h100, 0);
    push(GNT_IF, 0, 32'h0, 0);
    if_req = 1; if_addr = 0; dm_rd = 1; dm_addr = 32'h100;
    wait_done("tie_timeout");
    for (int i = 0; i < 4; i++) push(i[0] ? GNT_IF : GNT_DM, 0, i[0] ? 32'h4 : 32'h180, 0);
    if_req = 1; if_addr = 32'h4; dm_rd = 1; dm_addr = 32'h180;
    wait_done("fair_timeout");
    ack_dly = 1;
    push(GNT_DM, 1, 32'h200, 32'hDEAD_BEEF);
    dm_wr = 1; dm_addr = 32'h200; dm_wdata = 32'hDEAD_BEEF;
    wait_done("write_timeout");
    push(GNT_DM, 1, 32'h204, 32'h1234_5678);
    dm_rd = 1; dm_wr = 1; dm_addr = 32'h204; dm_wdata = 32'h1234_5678;
    wait_done("rdwr_timeout");
    for (int i = 0; i < 8; i++) begin
      sel = 2'($urandom_range(1, 3));
      w = 1'($urandom_range(0, 1));
      ack_dly = $urandom_range(0, 3);
      if_addr = 32'h800 + 4 * i;
      dm_addr = 32'hC00 + 4 * i;
      dm_wdata = $urandom;
      if (sel == 2'b11 && tb_last == GNT_DM) begin
        push(GNT_IF, 0, if_addr, 0);
        push(GNT_DM, w, dm_addr, dm_wdata);
      end else begin
        if (sel[1]) push(GNT_DM, w, dm_addr, dm_wdata);
        if (sel[0]) push(GNT_IF, 0, if_addr, 0);
      end
      if_req = sel[0]; dm_rd = sel[1] & ~w; dm_wr = sel[1] & w;
      wait_done("rand_timeout");
    end
    force_ack = 1;
    @(posedge clk); @(negedge clk);
    chk("spur_ready", {if_ready, dm_ready}, 0);
    @(posedge clk); #2;
    force_ack = 0;
    @(negedge clk);
    chk("spur_mem_req", mem_req, 0);
    chk("spur_if_rdata", if_rdata, exp_if);
    chk("spur_dm_rdata", dm_rdata, exp_dm);
    @(posedge clk); #2;
    ack_dly = 20;
    dm_rd = 1; dm_addr = 32'h300;
    @(posedge clk); #2;
    chk("mid_mem_req", mem_req, 1);
    rst = 1;
    #1;
    chk("mid_rst_mem_req", mem_req, 0);
    chk("mid_rst_ready", dm_ready, 0);
    dm_rd = 0; exp_if = 0; exp_dm = 0; tb_last = GNT_IF;
    @(posedge clk); #2;
    rst = 0; force_ack = 1;
    @(posedge clk); @(negedge clk);
    chk("post_rst_ack_ready", {if_ready, dm_ready}, 0);
    chk("post_rst_dm_rdata", dm_rdata, 0);
    @(posedge clk); #2;
    force_ack = 0; ack_dly = 0;
    push(GNT_DM, 0, 32'h140, 0);
    push(GNT_IF, 0, 32'h44, 0);
    if_req = 1; if_addr = 32'h44; dm_rd = 1; dm_addr = 32'h140;
    wait_done("tie2_timeout");
    repeat (2) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
